// File: rtl/nttr_read_checker.sv
// nttr_read_checker: AXI4 read master that reads back the traffic-writer pattern and scores every beat.
// Define NTTR_ERR_CAPTURE_EN to build the first-errored-beat capture outputs.

module nttr_lane_cmp (
  input  logic [31:0] data,
  input  logic [31:0] exp_data,
  output logic        mis
);
  assign mis = (data != exp_data);
endmodule

module nttr_read_checker #(
  parameter int                DATA_W     = 128,
  parameter int                ADDR_W     = 64,
  parameter int                ID_W       = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                BURST_LEN  = 16,
  parameter int                NUM_BURSTS = 64,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [ID_W-1:0]   m_arid,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  beat_cnt
`ifdef NTTR_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              first_err_vld
`endif
);
  localparam int                NUM_LANES   = DATA_W / 32;
  localparam logic [ADDR_W-1:0] BEAT_BYTES  = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));
  localparam logic [8:0]        LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [31:0]       LAST_BURST  = 32'(NUM_BURSTS - 1);
  localparam logic [31:0]       LANE_STEP   = 32'(NUM_LANES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                 state;
  logic                       start_q;
  logic [31:0]                burst_idx;
  logic [8:0]                 beat_idx;
  logic [31:0]                exp_base;
  logic [NUM_LANES-1:0][31:0] exp_lanes;
  logic [NUM_LANES-1:0]       lane_mis;
  logic                       launch, r_hs, beat_last, burst_end, beat_err;
  logic                       chk_vld, chk_err;

  assign m_arlen   = 8'(BURST_LEN - 1);
  assign m_arsize  = 3'($clog2(DATA_W / 8));
  assign m_arburst = 2'b01;
  assign m_arid    = '0;
  assign m_arvalid = (state == S_AR);
  assign m_rready  = (state == S_R);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign pass      = done && (err_cnt == '0);

  assign launch    = start && !start_q && (state == S_IDLE);
  assign r_hs      = m_rvalid && m_rready;
  assign beat_last = (beat_idx == LAST_BEAT);
  // A beat ends its burst on rlast or on reaching BURST_LEN, whichever comes first.
  assign burst_end = r_hs && (m_rlast || beat_last);
  assign beat_err  = (|lane_mis) || (m_rresp != 2'b00) || (m_rlast != beat_last);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign exp_lanes[k] = exp_base + 32'(k);
    nttr_lane_cmp u_cmp (
      .data     (m_rdata[32*k +: 32]),
      .exp_data (exp_lanes[k]),
      .mis      (lane_mis[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      burst_idx <= '0;
      beat_idx  <= '0;
      exp_base  <= '0;
      m_araddr  <= '0;
      done      <= 1'b0;
      err_cnt   <= '0;
      beat_cnt  <= '0;
      chk_vld   <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      start_q <= start;
      chk_vld <= r_hs;
      chk_err <= beat_err;
      if (chk_vld && chk_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (r_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
        exp_base <= exp_base + LANE_STEP;
        beat_idx <= beat_idx + 1'b1;
      end
      case (state)
        S_IDLE: if (launch) begin
          state     <= S_AR;
          done      <= 1'b0;
          err_cnt   <= '0;
          beat_cnt  <= '0;
          burst_idx <= '0;
          exp_base  <= '0;
          m_araddr  <= BASE_ADDR;
        end
        S_AR: if (m_arready) begin
          state    <= S_R;
          beat_idx <= '0;
        end
        S_R: if (burst_end) begin
          if (burst_idx == LAST_BURST) state <= S_CHK;
          else begin
            state     <= S_AR;
            burst_idx <= burst_idx + 1'b1;
            m_araddr  <= m_araddr + BURST_BYTES;
          end
        end
        // Final beat's check lands on this edge, so done and err_cnt appear together.
        S_CHK: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NTTR_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_addr       <= '0;
      chk_data       <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      first_err_vld  <= 1'b0;
    end else begin
      if (r_hs) begin
        chk_addr <= m_araddr + ADDR_W'(beat_idx) * BEAT_BYTES;
        chk_data <= m_rdata;
      end
      if (launch) begin
        first_err_addr <= '0;
        first_err_data <= '0;
        first_err_vld  <= 1'b0;
      end else if (chk_vld && chk_err && !first_err_vld) begin
        first_err_addr <= chk_addr;
        first_err_data <= chk_data;
        first_err_vld  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nttr_read_checker.sv
// Scoreboard bench for nttr_read_checker: procedural AXI read slave, expected addresses/results queued at launch.
// A second CNT_W=2 instance shares the stimulus to exercise err_cnt saturation.

module tb_nttr_read_checker;
  localparam int DATA_W = 128, ADDR_W = 64, ID_W = 1, BURST_LEN = 4, NUM_BURSTS = 3;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [ADDR_W-1:0] m_araddr, m_araddr2;
  logic [7:0]        m_arlen, m_arlen2;
  logic [2:0]        m_arsize, m_arsize2;
  logic [1:0]        m_arburst, m_arburst2;
  logic [ID_W-1:0]   m_arid, m_arid2;
  logic              m_arvalid, m_arvalid2, m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast, m_rvalid, m_rready, m_rready2;
  logic [ID_W-1:0]   m_rid;
  logic              busy, done, pass, busy2, done2, pass2;
  logic [15:0]       err_cnt, beat_cnt;
  logic [1:0]        err_cnt2, beat_cnt2;
`ifdef NTTR_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] fe_addr, fe_addr2;
  logic [DATA_W-1:0] fe_data, fe_data2;
  logic              fe_vld, fe_vld2;
`endif

  always #5 clk = ~clk;

  nttr_read_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .BASE_ADDR(64'h0),
    .BURST_LEN(BURST_LEN), .NUM_BURSTS(NUM_BURSTS), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .beat_cnt(beat_cnt)
`ifdef NTTR_ERR_CAPTURE_EN
    , .first_err_addr(fe_addr), .first_err_data(fe_data), .first_err_vld(fe_vld)
`endif
  );

  nttr_read_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .BASE_ADDR(64'h0),
    .BURST_LEN(BURST_LEN), .NUM_BURSTS(NUM_BURSTS), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .m_araddr(m_araddr2), .m_arlen(m_arlen2), .m_arsize(m_arsize2), .m_arburst(m_arburst2),
    .m_arid(m_arid2), .m_arvalid(m_arvalid2), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .beat_cnt(beat_cnt2)
`ifdef NTTR_ERR_CAPTURE_EN
    , .first_err_addr(fe_addr2), .first_err_data(fe_data2), .first_err_vld(fe_vld2)
`endif
  );

  typedef struct {
    logic [15:0] beats;
    logic [15:0] errs;
    logic [1:0]  errs_sat;
    logic        pass;
    logic        fe_vld;
    logic [63:0] fe_addr;
  } res_t;

  res_t        res_q[$];
  logic [63:0] addr_q[$];
  int          n_cmp = 0, n_mis = 0;

  // stimulus knobs
  logic [11:0] corrupt;
  int          resp_beat, norlast_burst, ar_stall;
  bit          gaps, restart_mid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_beat(input int b, input bit bad, input logic [1:0] resp, input bit last);
    for (int k = 0; k < 4; k++) m_rdata[32*k +: 32] = 32'(b * 4 + k);
    if (bad) m_rdata[63:32] = m_rdata[63:32] ^ 32'hdead_beef;
    m_rresp  = resp;
    m_rlast  = last;
    m_rvalid = 1'b1;
  endtask

  task automatic set_knobs(input logic [11:0] c, input int rb, input int nb, input int st, input bit g, input bit rm);
    corrupt = c; resp_beat = rb; norlast_burst = nb; ar_stall = st; gaps = g; restart_mid = rm;
  endtask

  task automatic run_test(input string name);
    res_t        r;
    int          errs, first, t;
    bit          e, stable;
    logic [63:0] hold;
    errs = 0; first = -1;
    for (int b = 0; b < 12; b++) begin
      e = corrupt[b] || (b == resp_beat) || ((b % 4 == 3) && (b / 4 == norlast_burst));
      if (e) begin
        errs++;
        if (first < 0) first = b;
      end
    end
    r.beats = 16'd12; r.errs = 16'(errs); r.errs_sat = (errs > 3) ? 2'd3 : 2'(errs);
    r.pass = (errs == 0); r.fe_vld = (first >= 0); r.fe_addr = (first >= 0) ? 64'(first * 16) : 64'h0;
    res_q.push_back(r);
    for (int i = 0; i < 3; i++) addr_q.push_back(64'(i * 64));

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int bu = 0; bu < 3; bu++) begin
      t = 0;
      while (!m_arvalid && t < 20) begin @(negedge clk); t++; end
      chk($sformatf("%s.arvalid%0d", name, bu), m_arvalid, 1);
      hold = m_araddr; stable = 1'b1;
      repeat (ar_stall) begin
        @(negedge clk);
        if (m_araddr !== hold || !m_arvalid) stable = 1'b0;
      end
      if (ar_stall > 0) chk($sformatf("%s.ar_stable%0d", name, bu), stable, 1);
      chk($sformatf("%s.araddr%0d", name, bu), m_araddr, addr_q.pop_front());
      m_arready = 1'b1;
      @(negedge clk) m_arready = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        if (restart_mid && bu == 1) start = (j < 2);
        drive_beat(bu * 4 + j, corrupt[bu * 4 + j], (bu * 4 + j == resp_beat) ? 2'b10 : 2'b00,
                   (j == 3) && (bu != norlast_burst));
        t = 0;
        while (!m_rready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) chk($sformatf("%s.rready%0d", name, bu), m_rready, 1);
        @(negedge clk);
        m_rvalid = 1'b0;
      end
      m_rlast = 1'b0; m_rresp = 2'b00;
    end
    start = 1'b0;

    t = 0;
    while (!done && t < 30) begin @(negedge clk); t++; end
    r = res_q.pop_front();
    chk({name, ".done"}, done, 1);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".beat_cnt"}, beat_cnt, r.beats);
    chk({name, ".err_cnt"}, err_cnt, r.errs);
    chk({name, ".pass"}, pass, r.pass);
    chk({name, ".err_cnt_sat"}, err_cnt2, r.errs_sat);
`ifdef NTTR_ERR_CAPTURE_EN
    chk({name, ".fe_vld"}, fe_vld, r.fe_vld);
    chk({name, ".fe_addr"}, fe_addr, r.fe_addr);
`endif
    repeat (3) @(negedge clk);
    chk({name, ".no_relaunch"}, m_arvalid, 0);
    chk({name, ".done_held"}, done, 1);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    m_rlast = 1'b0; m_rid = '0; m_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.err_cnt", err_cnt, 0);
    chk("rst.beat_cnt", beat_cnt, 0);
    chk("rst.arvalid", m_arvalid, 0);
    chk("rst.rready", m_rready, 0);
    chk("rst.araddr", m_araddr, 0);
    chk("const.arlen", m_arlen, 3);
    chk("const.arsize", m_arsize, 4);
    chk("const.arburst", m_arburst, 1);

    set_knobs(12'h000, -1, -1, 0, 0, 0);  run_test("ideal");
    set_knobs(12'h020, -1, -1, 0, 0, 0);  run_test("corrupt5");
    set_knobs(12'h000, 11, -1, 0, 0, 0);  run_test("resp_last");
    set_knobs(12'h000, -1, 0, 0, 0, 0);   run_test("norlast0");
    set_knobs(12'h000, -1, -1, 10, 1, 1); run_test("stall_gap");
    set_knobs(12'h529, -1, -1, 0, 1, 0);  run_test("sat5");

    // reset while in the R phase of burst 0, with one error already counted
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (!m_arvalid && t < 20) begin @(negedge clk); t++; end
    m_arready = 1'b1;
    @(negedge clk) m_arready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive_beat(j, j == 0, 2'b00, 1'b0);
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst.err_cnt", err_cnt, 1);
    chk("pre_rst.beat_cnt", beat_cnt, 2);
    chk("pre_rst.rready", m_rready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst.arvalid", m_arvalid, 0);
    chk("mid_rst.rready", m_rready, 0);
    chk("mid_rst.done", done, 0);
    chk("mid_rst.err_cnt", err_cnt, 0);
    chk("mid_rst.beat_cnt", beat_cnt, 0);
    chk("mid_rst.busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    set_knobs(12'h000, -1, -1, 0, 0, 0);  run_test("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
